fetch_decode_queue: RTL and testbench

- Packet-granular FIFO between the instruction-fetch stage and the decode stage.
- Buffers 2-wide fetch packets (f_d_pkg_t: 8-byte-aligned pc, 2-bit mask, two insts, predict_infos, fetch_exc_info) and presents the head packet to the decode stage's handshake receiver.
- Absorbs decode-side backpressure and discards all contents on a pipeline flush (branch mispredict / exception redirect).

---
 rtl/fetch_decode_queue_pkg.sv | 29 ++
 rtl/handshake_if.sv | 22 ++
 rtl/fetch_decode_queue.sv | 77 +++++++
 tb/tb_fetch_decode_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_queue_pkg.sv
// Shared fetch/decode types and the fetch-exception helper.
// Decode and the fetch-decode queue both use fetch_exc_valid.
package fetch_decode_queue_pkg;

    typedef struct packed {
        logic        taken;
        logic [29:0] target;
    } predict_info_t;

    typedef struct packed {
        logic adef;
        logic tlbr;
        logic pif;
        logic ppi;
    } fetch_exc_info_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [1:0]         mask;
        logic [1:0][31:0]   insts;
        predict_info_t [1:0] predict_infos;
        fetch_exc_info_t    fetch_exc_info;
    } f_d_pkg_t;

    function automatic logic fetch_exc_valid(input fetch_exc_info_t e);
        return e.adef | e.tlbr | e.pif | e.ppi;
    endfunction

endpackage

// File: rtl/handshake_if.sv
// Valid/ready handshake carrying one fetch packet.
// The receiver modport consumes data; the sender modport produces it.
interface handshake_if;
    import fetch_decode_queue_pkg::*;

    logic     valid;
    logic     ready;
    f_d_pkg_t data;

    modport sender (
        output valid,
        output data,
        input  ready
    );

    modport receiver (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/fetch_decode_queue.sv
// Packet FIFO between fetch and decode.
// Registered output, no empty bypass, flush empties the queue.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    handshake_if.receiver    receiver,
    handshake_if.sender      sender,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    f_d_pkg_t         r_mem [DEPTH];
    logic [PTR_W:0]   r_head;
    logic [PTR_W:0]   r_tail;

    logic             w_empty;
    logic             w_full;
    logic             w_keep;
    logic             w_enq;
    logic             w_deq;

    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[PTR_W-1:0] == r_tail[PTR_W-1:0])
                  && (r_head[PTR_W] != r_tail[PTR_W]);

    assign receiver.ready = !w_full;
    assign sender.valid   = !w_empty;
    assign sender.data    = r_mem[r_head[PTR_W-1:0]];

    // Empty-mask packets without an exception carry nothing for decode.
    assign w_keep = (|receiver.data.mask)
                 || fetch_exc_valid(receiver.data.fetch_exc_info);

    assign w_enq   = receiver.valid && !w_full && w_keep;
    assign w_deq   = sender.ready && !w_empty;
    assign count_o = r_tail - r_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_deq) begin
                r_head <= r_head + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail[PTR_W-1:0]] <= receiver.data;
        end
    end

    a_no_deq_empty : assert property (
        @(posedge clk) disable iff (rst) !(w_deq && w_empty));

    a_no_enq_full : assert property (
        @(posedge clk) disable iff (rst) !(w_enq && w_full));

    a_count_bound : assert property (
        @(posedge clk) disable iff (rst) (int'(count_o) <= DEPTH));

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed and random stimulus for fetch_decode_queue.
// A queue-based reference model predicts every output.
module tb_fetch_decode_queue;
    import fetch_decode_queue_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    f_d_pkg_t q[$];
    bit       last_acc;

    handshake_if u_rx ();
    handshake_if u_tx ();

    fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .receiver (u_rx),
        .sender   (u_tx),
        .count_o  (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pkt(input string tag, input f_d_pkg_t obs,
                           input f_d_pkg_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic f_d_pkg_t mk(input logic [31:0] pc,
                                    input logic [1:0] mask,
                                    input logic [3:0] exc);
        f_d_pkg_t p;
        p.pc                      = pc;
        p.mask                    = mask;
        p.insts[0]                = $urandom;
        p.insts[1]                = $urandom;
        p.predict_infos[0].taken  = 1'($urandom);
        p.predict_infos[0].target = 30'($urandom);
        p.predict_infos[1].taken  = 1'($urandom);
        p.predict_infos[1].target = 30'($urandom);
        p.fetch_exc_info          = exc;
        return p;
    endfunction

    // Packet is worth storing when it has an instruction or an exception.
    function automatic bit model_keep(input f_d_pkg_t p);
        return (p.mask != 2'b00) || (p.fetch_exc_info != 4'b0000);
    endfunction

    // Check outputs against the model, then advance one clock.
    task automatic step();
        bit acc;
        bit pop;
        chk("valid", 32'(u_tx.valid), 32'(q.size() != 0));
        chk("ready", 32'(u_rx.ready), 32'(q.size() < DEPTH));
        chk("count", 32'(count), 32'(q.size()));
        if (q.size() != 0) chk_pkt("data", u_tx.data, q[0]);
        acc = u_rx.valid && (q.size() < DEPTH);
        pop = u_tx.ready && (q.size() != 0);
        last_acc = acc;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc && model_keep(u_rx.data)) q.push_back(u_rx.data);
        end
        @(negedge clk);
    endtask

    task automatic push(input f_d_pkg_t p);
        bit done;
        done = 1'b0;
        u_rx.valid = 1'b1;
        u_rx.data  = p;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = last_acc;
        end
        u_rx.valid = 1'b0;
        chk("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic drain();
        u_rx.valid = 1'b0;
        u_tx.ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        chk("drained", 32'(count), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        u_rx.valid = 1'b0;
        u_rx.data  = '0;
        u_tx.ready = 1'b0;
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(u_tx.valid), 32'd0);
        chk("rst_ready", 32'(u_rx.ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Fill with decode stalled, then release.
        for (int k = 0; k < 4; k++)
            push(mk(32'h1c00_0000 + 32'(8 * k), 2'b11, 4'h0));
        chk("fill_count", 32'(count), 32'd4);
        u_rx.valid = 1'b1;
        u_rx.data  = mk(32'h1c00_0020, 2'b11, 4'h0);
        for (int i = 0; i < 3; i++) step();
        chk("full_ready", 32'(u_rx.ready), 32'd0);
        u_tx.ready = 1'b1;
        push(u_rx.data);
        drain();

        // Single packet into an empty queue.
        u_tx.ready = 1'b1;
        push(mk(32'h1c00_0100, 2'b11, 4'h0));
        step();
        step();

        // Steady push/pop at occupancy two.
        u_tx.ready = 1'b0;
        push(mk(32'h1c00_0200, 2'b11, 4'h0));
        push(mk(32'h1c00_0208, 2'b10, 4'h0));
        u_tx.ready = 1'b1;
        u_rx.valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            u_rx.data = mk(32'h1c00_0210 + 32'(8 * i), 2'b11, 4'h0);
            step();
            chk("pushpop_count", 32'(count), 32'd2);
        end
        drain();

        // Drop rule.
        u_tx.ready = 1'b0;
        push(mk(32'h1c00_0300, 2'b00, 4'h0));
        push(mk(32'h1c00_0308, 2'b00, 4'h8));
        push(mk(32'h1c00_0310, 2'b01, 4'h0));
        step();
        chk("drop_count", 32'(count), 32'd2);
        drain();

        // Flush with concurrent push and pop.
        u_tx.ready = 1'b0;
        for (int k = 0; k < 3; k++)
            push(mk(32'h1c00_0400 + 32'(8 * k), 2'b11, 4'h0));
        u_rx.valid = 1'b1;
        u_rx.data  = mk(32'h1c00_0418, 2'b11, 4'h0);
        u_tx.ready = 1'b1;
        flush      = 1'b1;
        step();
        flush      = 1'b0;
        u_rx.valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(u_tx.valid), 32'd0);
        chk("flush_ready", 32'(u_rx.ready), 32'd1);
        step();

        // Held flush discards accepted packets.
        u_rx.valid = 1'b1;
        flush      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_rx.data = mk(32'h1c00_0500 + 32'(8 * i), 2'b11, 4'h0);
            step();
        end
        flush      = 1'b0;
        u_rx.valid = 1'b0;
        chk("hold_flush_count", 32'(count), 32'd0);
        step();

        // Asynchronous reset mid-cycle.
        u_tx.ready = 1'b0;
        for (int k = 0; k < 3; k++)
            push(mk(32'h1c00_0600 + 32'(8 * k), 2'b11, 4'h0));
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(u_tx.valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ready", 32'(u_rx.ready), 32'd1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        u_tx.ready = 1'b1;
        push(mk(32'h1c00_0700, 2'b11, 4'h0));
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            u_rx.valid = 1'($urandom_range(0, 1));
            u_rx.data  = mk(32'h1c00_1000 + 32'(8 * i), 2'($urandom),
                            ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
            if (i < 200) u_tx.ready = ($urandom_range(0, 2) == 0);
            else         u_tx.ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
